// File: rtl/lb_byte_master.sv
// LocalBus byte-stream master: decodes CMD/LEN/ADDR frames from a host link
// into lb_wr/lb_rd strobes and streams read data back as bytes.
//
// Ports:
//   clk_lb, reset           clock and synchronous active-high reset
//   rx_byte_d/rx_byte_rdy   incoming command bytes (no backpressure)
//   tx_byte_d/tx_byte_rdy   outgoing response bytes, held until tx_byte_ack
//   lb_wr/lb_rd/lb_addr     bus strobes and address
//   lb_wr_d/lb_rd_d         write data out, read data in (with lb_rd_rdy)
//   busy                    high whenever a frame is in progress
//   rd_timeout_err          pulse when a read gets no response in time
//   rx_drop                 pulse when an rx byte is discarded during a read
module lb_byte_master #(
  parameter int          rd_timeout = 255,
  parameter logic [31:0] timeout_d  = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic [7:0]  rx_byte_d,
  input  logic        rx_byte_rdy,
  output logic [7:0]  tx_byte_d,
  output logic        tx_byte_rdy,
  input  logic        tx_byte_ack,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        busy,
  output logic        rd_timeout_err,
  output logic        rx_drop
);

  typedef enum logic [2:0] {
    IDLE, HDR, WR_DATA, WR_STB, RD_STB, RD_WAIT, TX
  } state_t;

  localparam logic [15:0] to_cyc = 16'(rd_timeout);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  hdr_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  count;
  logic [31:0] addr;
  logic [31:0] wr_d;
  logic [31:0] rd_q;
  logic [15:0] timer;
  logic        is_rd;

  logic cmd_ok;
  logic tx_xfer;
  logic to_hit;

  assign cmd_ok  = rx_byte_rdy &&
                   (rx_byte_d == 8'h57 || rx_byte_d == 8'h52);
  assign tx_xfer = (state == TX) && tx_byte_ack;
  // A response arriving on the timeout cycle takes priority over the timeout.
  assign to_hit  = (state == RD_WAIT) && !lb_rd_rdy && (timer == to_cyc);

  always_ff @(posedge clk_lb) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_ok) state_nx = HDR;
      HDR:
        if (rx_byte_rdy && hdr_cnt == 3'd4)
          state_nx = is_rd ? RD_STB : WR_DATA;
      WR_DATA:
        if (rx_byte_rdy && byte_cnt == 2'd3)
          state_nx = WR_STB;
      // A byte landing on the last strobe may already start a new frame.
      WR_STB:
        if (count != 8'd0) state_nx = WR_DATA;
        else if (cmd_ok)   state_nx = HDR;
        else               state_nx = IDLE;
      RD_STB: state_nx = RD_WAIT;
      RD_WAIT: if (lb_rd_rdy || to_hit) state_nx = TX;
      TX:
        if (tx_xfer && byte_cnt == 2'd3)
          state_nx = (count == 8'd0) ? IDLE : RD_STB;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_lb) begin
    if (reset) begin
      hdr_cnt  <= '0;
      byte_cnt <= '0;
      count    <= '0;
      addr     <= '0;
      wr_d     <= '0;
      rd_q     <= '0;
      timer    <= '0;
      is_rd    <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (cmd_ok) begin
            is_rd   <= (rx_byte_d == 8'h52);
            hdr_cnt <= '0;
          end
        HDR: begin
          byte_cnt <= '0;
          if (rx_byte_rdy) begin
            hdr_cnt <= hdr_cnt + 3'd1;
            if (hdr_cnt == 3'd0) count <= rx_byte_d;
            else                 addr  <= {addr[23:0], rx_byte_d};
          end
        end
        WR_DATA:
          if (rx_byte_rdy) begin
            wr_d     <= {wr_d[23:0], rx_byte_d};
            byte_cnt <= byte_cnt + 2'd1;
          end
        WR_STB: begin
          addr <= addr + 32'd4;
          if (count != 8'd0) begin
            count    <= count - 8'd1;
            byte_cnt <= rx_byte_rdy ? 2'd1 : 2'd0;
            if (rx_byte_rdy) wr_d <= {wr_d[23:0], rx_byte_d};
          end else if (cmd_ok) begin
            is_rd   <= (rx_byte_d == 8'h52);
            hdr_cnt <= '0;
          end
        end
        // Timer reads 1 on the first cycle after lb_rd.
        RD_STB: timer <= 16'd1;
        RD_WAIT: begin
          timer    <= timer + 16'd1;
          byte_cnt <= '0;
          if (lb_rd_rdy)   rd_q <= lb_rd_d;
          else if (to_hit) rd_q <= timeout_d;
        end
        TX:
          if (tx_xfer) begin
            rd_q     <= {rd_q[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr <= addr + 32'd4;
              if (count != 8'd0) count <= count - 8'd1;
            end
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    lb_wr          = (state == WR_STB);
    lb_rd          = (state == RD_STB);
    tx_byte_rdy    = (state == TX);
    tx_byte_d      = (state == TX) ? rd_q[31:24] : 8'h00;
    busy           = (state != IDLE);
    rd_timeout_err = to_hit;
    rx_drop        = rx_byte_rdy &&
                     (state == RD_STB || state == RD_WAIT || state == TX);
    lb_addr        = addr;
    lb_wr_d        = wr_d;
  end

endmodule

// File: tb/tb_lb_byte_master.sv
// Scoreboard bench for lb_byte_master: stimulus queues expected bus/tx
// events, a monitor pops and compares them as the DUT produces them.
module tb_lb_byte_master;

  logic        clk_lb = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  rx_byte_d = '0;
  logic        rx_byte_rdy = 1'b0;
  logic [7:0]  tx_byte_d;
  logic        tx_byte_rdy;
  logic        tx_byte_ack = 1'b0;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d = '0;
  logic        lb_rd_rdy = 1'b0;
  logic        busy;
  logic        rd_timeout_err;
  logic        rx_drop;

  lb_byte_master #(.rd_timeout(255), .timeout_d(32'hDEADBEEF)) dut (
    .clk_lb(clk_lb), .reset(reset),
    .rx_byte_d(rx_byte_d), .rx_byte_rdy(rx_byte_rdy),
    .tx_byte_d(tx_byte_d), .tx_byte_rdy(tx_byte_rdy),
    .tx_byte_ack(tx_byte_ack),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr),
    .lb_wr_d(lb_wr_d), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
    .busy(busy), .rd_timeout_err(rd_timeout_err), .rx_drop(rx_drop)
  );

  always #5 clk_lb = ~clk_lb;

  localparam int EV_WR = 0, EV_RD = 1, EV_TX = 2, EV_TO = 3, EV_DROP = 4;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         q[$];
  logic [31:0] rdata_q[$];
  logic [7:0]  frame[$];
  int compared = 0, mismatched = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int rd_count = 0;
  int resp_delay = 3;
  bit resp_en = 1'b1;
  int ack_stall = 0;

  always @(posedge clk_lb) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic expect_tx(logic [31:0] w);
    for (int i = 3; i >= 0; i--) expect_ev(EV_TX, 32'h0, {24'h0, w[8*i +: 8]});
  endtask

  task automatic got_ev(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d a=%h d=%h, none queued",
               k, a, d);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.a !== a || e.d !== d) begin
        mismatched++;
        $display("FAIL event: got kind %0d a=%h d=%h want kind %0d a=%h d=%h",
                 k, a, d, e.k, e.a, e.d);
      end
    end
  endtask

  // Monitor
  initial begin
    logic [7:0] prev_d;
    bit prev_hold;
    prev_hold = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk_lb);
      if (!reset) begin
        if (lb_wr) got_ev(EV_WR, lb_addr, lb_wr_d);
        if (lb_rd) begin
          got_ev(EV_RD, lb_addr, 32'h0);
          rd_cyc = cyc;
          rd_count++;
        end
        if (tx_byte_rdy && tx_byte_ack)
          got_ev(EV_TX, 32'h0, {24'h0, tx_byte_d});
        if (rd_timeout_err) begin
          got_ev(EV_TO, 32'h0, 32'h0);
          check("timeout_latency", 32'(cyc - rd_cyc), 32'd255);
        end
        if (rx_drop) got_ev(EV_DROP, 32'h0, 32'h0);
        if (prev_hold && tx_byte_rdy)
          check("tx_hold", {24'h0, tx_byte_d}, {24'h0, prev_d});
        prev_hold = tx_byte_rdy && !tx_byte_ack;
        prev_d = tx_byte_d;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // Bus responder: answers each lb_rd after resp_delay cycles.
  initial forever begin
    @(negedge clk_lb);
    if (lb_rd && resp_en) begin
      repeat (resp_delay) @(posedge clk_lb);
      #1;
      lb_rd_rdy = 1'b1;
      lb_rd_d = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
      @(posedge clk_lb);
      #1;
      lb_rd_rdy = 1'b0;
    end
  end

  // Tx consumer: stalls ack_stall cycles per byte.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_lb);
      #1;
      if (tx_byte_ack) begin
        tx_byte_ack = 1'b0;
        cnt = 0;
      end else if (tx_byte_rdy) begin
        if (cnt >= ack_stall) tx_byte_ack = 1'b1;
        else cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_lb);
    #1;
  endtask

  task automatic send(logic [7:0] b, int gap);
    rx_byte_d = b;
    rx_byte_rdy = 1'b1;
    tick();
    rx_byte_rdy = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(int gap);
    foreach (frame[i]) send(frame[i], gap);
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_quiet(string name);
    check({name, "_strobes"},
          {26'h0, lb_wr, lb_rd, tx_byte_rdy, busy, rd_timeout_err, rx_drop},
          32'h0);
    check({name, "_tx_d"}, {24'h0, tx_byte_d}, 32'h0);
    check({name, "_addr"}, lb_addr, 32'h0);
    check({name, "_wr_d"}, lb_wr_d, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int n;
    repeat (3) tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    // Single write, one byte every 10 cycles
    expect_ev(EV_WR, 32'h10, 32'h1);
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    send_frame(9);
    send(8'h01, 0);
    check("single_wr_strobe", {31'h0, lb_wr}, 32'h1);
    check("single_wr_addr", lb_addr, 32'h10);
    tick();
    check("single_wr_busy", {30'h0, busy, lb_wr}, 32'h0);

    // Burst write at full rate with address wrap
    expect_ev(EV_WR, 32'hFFFFFFF8, 32'h11111111);
    expect_ev(EV_WR, 32'hFFFFFFFC, 32'h22222222);
    expect_ev(EV_WR, 32'h00000000, 32'h33333333);
    frame = '{8'h57, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hF8,
              8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
              8'h33, 8'h33, 8'h33, 8'h33};
    send_frame(0);
    wait_idle("burst_wr", 50);

    // Single read, responder 3 cycles late, tx stalled 5 cycles per byte
    ack_stall = 5;
    resp_delay = 3;
    rdata_q.push_back(32'h11223344);
    expect_ev(EV_RD, 32'h40, 32'h0);
    expect_tx(32'h11223344);
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    send_frame(0);
    wait_idle("single_rd", 500);

    // Read timeout
    ack_stall = 0;
    resp_en = 1'b0;
    expect_ev(EV_RD, 32'h80, 32'h0);
    expect_ev(EV_TO, 32'h0, 32'h0);
    expect_tx(32'hDEADBEEF);
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    send_frame(0);
    wait_idle("timeout_rd", 1000);

    // Response on exactly the timeout cycle, plus an rx byte mid-wait
    resp_en = 1'b1;
    resp_delay = 255;
    rdata_q.push_back(32'hCAFEF00D);
    expect_ev(EV_RD, 32'h84, 32'h0);
    expect_ev(EV_DROP, 32'h0, 32'h0);
    expect_tx(32'hCAFEF00D);
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h84};
    send_frame(0);
    repeat (100) tick();
    send(8'h57, 0);
    wait_idle("edge_rd", 1000);

    // Junk byte in IDLE then a normal read
    resp_delay = 2;
    rdata_q.push_back(32'h0BADCAFE);
    expect_ev(EV_RD, 32'hC0, 32'h0);
    expect_tx(32'h0BADCAFE);
    send(8'hAA, 3);
    check("junk_busy", {31'h0, busy}, 32'h0);
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0};
    send_frame(0);
    wait_idle("junk_rd", 200);

    // Reset in the middle of a 4-dword burst read
    ack_stall = 5;
    rc = rd_count;
    rdata_q.push_back(32'hA0000001);
    rdata_q.push_back(32'hA0000002);
    rdata_q.push_back(32'hA0000003);
    expect_ev(EV_RD, 32'h100, 32'h0);
    expect_tx(32'hA0000001);
    expect_ev(EV_RD, 32'h104, 32'h0);
    expect_tx(32'hA0000002);
    expect_ev(EV_RD, 32'h108, 32'h0);
    frame = '{8'h52, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00};
    send_frame(0);
    n = 0;
    while (!(rd_count == rc + 3 && tx_byte_rdy) && n < 2000) begin
      tick();
      n++;
    end
    check("burst_reach_tx3", 32'(rd_count - rc), 32'd3);
    reset = 1'b1;
    tick();
    check_quiet("mid_reset");
    reset = 1'b0;
    rc = rd_count;
    repeat (300) tick();
    check("no_rd_after_reset", 32'(rd_count - rc), 32'd0);
    check("queue_after_reset", 32'(q.size()), 32'd0);
    rdata_q.delete();

    // Fresh write after reset
    expect_ev(EV_WR, 32'h100, 32'hDEC0ADE0);
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'hDE, 8'hC0, 8'hAD, 8'hE0};
    send_frame(1);
    wait_idle("fresh_wr", 50);
    repeat (5) tick();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lb_byte_master.md
Name: lb_byte_master

Overview:
- LocalBus initiator: turns a framed byte stream (from the UART/host link) into single-cycle lb_wr/lb_rd strobes on clk_lb.
- Returns read data as bytes on a transmit stream.
- It is the master end of the bus that core-level register decoders and sump2 respond to.
- Supports burst writes and burst reads with an auto-incrementing address and a read-response timeout.

Parameters:
- rd_timeout, 255: cycles to wait for lb_rd_rdy after lb_rd before substituting timeout data (1..65535).
- timeout_d, 32'hDEADBEEF: dword returned on read timeout.

Ports:
- clk_lb  input  1  sole clock.
- reset  input  1  synchronous, active-high.
- rx_byte_d  input  8  received command byte.
- rx_byte_rdy  input  1  one-cycle strobe: rx_byte_d valid; no backpressure.
- tx_byte_d  output  8  response byte.
- tx_byte_rdy  output  1  response byte valid; held until accepted.
- tx_byte_ack  input  1  consumer ready; a byte transfers when tx_byte_rdy and tx_byte_ack are both 1.
- lb_wr  output  1  one-cycle write strobe.
- lb_rd  output  1  one-cycle read strobe.
- lb_addr  output  32  bus address; valid with either strobe.
- lb_wr_d  output  32  write data; valid with lb_wr.
- lb_rd_d  input  32  read data; valid with lb_rd_rdy.
- lb_rd_rdy  input  1  read-data-valid strobe from responders.
- busy  output  1  1 in any state other than IDLE.
- rd_timeout_err  output  1  one-cycle pulse when a read times out.
- rx_drop  output  1  one-cycle pulse when an rx byte is discarded.

Behaviour:
- Frame format: CMD, LEN, A3, A2, A1, A0, then payload. All multi-byte fields MSB first.
  - CMD 8'h57 = write; CMD 8'h52 = read.
  - LEN = dword count minus 1, so 1..256 dwords.
  - Write payload: (LEN+1) x 4 data bytes. Read frames carry no payload.
- Reset:
  - All outputs 0, tx_byte_d 0.
  - State IDLE; internal address, count and shift registers cleared.
  - Reset mid-frame or mid-read abandons the transaction with no further strobes.
- States: IDLE, HDR (LEN plus 4 address bytes), WR_DATA, WR_STB, RD_STB, RD_WAIT, TX.
- IDLE:
  - 8'h57 or 8'h52 on rx_byte_rdy moves to HDR.
  - Any other byte is ignored silently (resync); rx_drop stays 0.
- HDR: 5 bytes accepted, then goes to WR_DATA for writes or RD_STB for reads.
- WR_DATA: shifts in 4 bytes into lb_wr_d; after the 4th byte goes to WR_STB.
- WR_STB (one cycle):
  - lb_wr=1 with lb_addr and lb_wr_d stable; the strobe fires the cycle after the 4th byte is strobed in.
  - Then lb_addr += 4 (wraps mod 2^32) and count decrements.
  - If count was 0 go to IDLE, else WR_DATA.
  - An rx byte arriving in WR_STB is accepted as the first byte of the next dword, so no loss at full UART rate.
- RD_STB (one cycle): lb_rd=1 with lb_addr; go to RD_WAIT and clear the timer.
- RD_WAIT:
  - The timer counts from the cycle after lb_rd.
  - lb_rd_rdy=1 captures lb_rd_d and goes to TX.
  - When the timer reaches rd_timeout with no rdy: capture timeout_d, pulse rd_timeout_err, go to TX.
  - lb_rd_rdy in the same cycle as the timeout match wins: real data, no error pulse.
  - lb_rd_rdy outside RD_WAIT is ignored.
- TX:
  - Presents 4 bytes MSB first. tx_byte_rdy=1 and tx_byte_d are stable until tx_byte_ack.
  - The next byte is presented the cycle after a transfer.
  - After the 4th transfer, lb_addr += 4. If count was 0 go to IDLE, else decrement and go to RD_STB.
- Any rx_byte_rdy during RD_STB, RD_WAIT or TX is discarded with a one-cycle rx_drop pulse.
- lb_wr and lb_rd are never 1 in the same cycle and are never asserted for 2 consecutive cycles.
- busy falls in the same cycle the state returns to IDLE.

Test Plan:
- Single write: rx 57 00 00 00 00 10 00 00 00 01, one byte every 10 cycles -> exactly one lb_wr pulse, one cycle after the last byte, with lb_addr=32'h10 and lb_wr_d=32'h1; busy=0 the next cycle.
- Burst write: LEN=2, addr 32'hFFFFFFF8, data 11111111/22222222/33333333 -> lb_wr at addrs FFFFFFF8, FFFFFFFC, 00000000 (wrap) with matching data; 3 pulses total.
- Single read, responder rdy 3 cycles after lb_rd returning 32'h11223344, tx_byte_ack stalled 5 cycles per byte -> tx bytes 11 22 33 44 in order; each byte held stable while ack=0.
- Read timeout, no responder, rd_timeout=255 -> rd_timeout_err pulses once 255 cycles after lb_rd; tx bytes DE AD BE EF.
- Boundaries:
  - lb_rd_rdy on exactly cycle 255 -> real data and no error.
  - rx byte during RD_WAIT -> rx_drop pulse; state unaffected.
  - Junk byte 8'hAA in IDLE -> ignored; the following 8'h52 frame executes normally.
- Reset asserted mid-burst read (after the 2nd dword, during TX) -> all outputs 0 the next cycle, state IDLE, no further lb_rd; a fresh frame afterwards works.
